// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding imem requester feeding a
// first-word fall-through prefetch FIFO of {pc, word} with redirect flush.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FLUSH
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  count_q, count_d, count_nx;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [31:0]    fpc_q, fpc_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    pc_mem   [DEPTH];
  logic [31:0]    word_mem [DEPTH];
  logic           push, pop, space;

  // Space is judged on the occupancy after this cycle's push/pop,
  // so a new request never overcommits the buffer.
  assign pop      = inst_valid & inst_ready & ~redirect;
  assign count_nx = count_q + CW'(push) - CW'(pop);
  assign space    = count_nx < CW'(DEPTH);

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!redirect && space) state_d = REQ;
      end
      REQ: begin
        if (redirect)      state_d = imem_ack ? REQ : FLUSH;
        else if (imem_ack) state_d = space ? REQ : IDLE;
      end
      FLUSH: begin
        if (imem_ack) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state_q != IDLE);
    imem_addr = addr_q;
    push      = (state_q == REQ) & imem_ack & ~redirect;
  end

  always_comb begin
    fpc_d  = fpc_q;
    addr_d = addr_q;
    if (redirect)  fpc_d = redirect_pc;
    else if (push) fpc_d = fpc_q + 32'd1;
    // FLUSH keeps presenting the stale address until it is acked.
    if (state_d == REQ) addr_d = fpc_d;
    if (redirect) begin
      count_d = '0;
      rptr_d  = '0;
      wptr_d  = '0;
    end else begin
      count_d = count_nx;
      rptr_d  = rptr_q + AW'(pop);
      wptr_d  = wptr_q + AW'(push);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      fpc_q   <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      count_q <= count_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      fpc_q   <= fpc_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wptr_q]   <= fpc_q;
      word_mem[wptr_q] <= imem_rdata;
    end
  end

  assign inst_valid = (count_q != '0);
  assign inst       = word_mem[rptr_q];
  assign inst_pc    = pc_mem[rptr_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table plus reset, flush
// chaining and pc wrap sequences.
module tb_fetch_unit;

  localparam logic [31:0] MAGIC = 32'hC0DE0000;

  logic        clock = 1'b0;
  logic        reset_n, imem_ack, redirect, inst_ready;
  logic [31:0] redirect_pc;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, imem_rdata, inst, inst_pc;
  logic        b_req, b_valid;
  logic [31:0] b_addr, b_rdata, b_inst, b_pc;

  always #5 clock = ~clock;

  assign imem_rdata = imem_addr ^ MAGIC;
  assign b_rdata    = b_addr ^ MAGIC;

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h100)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .imem_req(b_req), .imem_addr(b_addr),
    .imem_ack(imem_ack), .imem_rdata(b_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(b_valid), .inst(b_inst),
    .inst_pc(b_pc), .inst_ready(inst_ready)
  );

  typedef struct {
    bit          rst;
    bit          ack;
    bit          rdy;
    bit          rd;
    logic [31:0] rpc;
    bit          req;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(bit rst, bit ack, bit rdy, bit rd,
                       logic [31:0] rpc);
    @(negedge clock);
    reset_n     = rst;
    imem_ack    = ack;
    inst_ready  = rdy;
    redirect    = rd;
    redirect_pc = rpc;
  endtask

  task automatic expect_out(string tag, bit req, logic [31:0] addr,
                            bit vld, logic [31:0] pc);
    chk($sformatf("%s req", tag), 32'(imem_req), 32'(req));
    if (req) chk($sformatf("%s addr", tag), imem_addr, addr);
    chk($sformatf("%s valid", tag), 32'(inst_valid), 32'(vld));
    if (vld) begin
      chk($sformatf("%s pc", tag), inst_pc, pc);
      chk($sformatf("%s inst", tag), inst, pc ^ MAGIC);
    end
  endtask

  function automatic vec_t mk(bit rst, bit ack, bit rdy, bit rd,
                              logic [31:0] rpc, bit req,
                              logic [31:0] addr, bit vld,
                              logic [31:0] pc);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdy = rdy; v.rd = rd; v.rpc = rpc;
    v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
    return v;
  endfunction

  initial begin
    // fill from reset, ack tied 1, no consumer
    tbl.push_back(mk(0, 1, 0, 0, 0,      0, 0,      0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0,      0, 0,      0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0,      1, 0,      0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0,      1, 1,      1, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0,      1, 2,      1, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0,      1, 3,      1, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0,      0, 0,      1, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0,      0, 0,      1, 0));
    // stream with consumer ready
    tbl.push_back(mk(1, 1, 1, 0, 0,      0, 0,      1, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0,      1, 4,      1, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0,      1, 5,      1, 2));
    tbl.push_back(mk(1, 1, 1, 0, 0,      1, 6,      1, 3));
    tbl.push_back(mk(1, 1, 0, 0, 0,      1, 7,      1, 4));
    // buffer holds 4..7, idle: redirect to 0x40
    tbl.push_back(mk(1, 1, 1, 1, 'h40,   0, 0,      1, 4));
    tbl.push_back(mk(1, 1, 1, 0, 0,      0, 0,      0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0,      1, 'h40,   0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0,      1, 'h41,   1, 'h40));
    tbl.push_back(mk(1, 1, 1, 0, 0,      1, 'h42,   1, 'h41));
    // redirect with ack: data dropped, refetch at 5
    tbl.push_back(mk(1, 1, 1, 1, 5,      1, 'h43,   1, 'h42));
    // pc 5 outstanding, redirect to 0x80, ack two cycles later
    tbl.push_back(mk(1, 0, 1, 1, 'h80,   1, 5,      0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0,      1, 5,      0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0,      1, 5,      0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0,      1, 'h80,   0, 0));
    // ack held low three cycles
    tbl.push_back(mk(1, 0, 1, 0, 0,      1, 'h81,   1, 'h80));
    tbl.push_back(mk(1, 0, 1, 0, 0,      1, 'h81,   0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0,      1, 'h81,   0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0,      1, 'h81,   0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,      1, 'h82,   1, 'h81));

    reset_n     = 1'b0;
    imem_ack    = 1'b0;
    inst_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    repeat (2) @(posedge clock);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].ack, tbl[i].rdy, tbl[i].rd, tbl[i].rpc);
      expect_out($sformatf("row%0d", i), tbl[i].req, tbl[i].addr,
                 tbl[i].vld, tbl[i].pc);
    end

    // reset while a request is pending; ack during reset ignored
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    expect_out("rst_mid", 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    expect_out("rst_rel", 0, 0, 0, 0);
    chk("b_rst_req", 32'(b_req), 32'd0);
    drive(1, 0, 0, 0, 0);
    expect_out("first_req", 1, 32'h0, 0, 0);
    chk("b_first_req", 32'(b_req), 32'd1);
    chk("b_first_addr", b_addr, 32'h100);

    // chained redirects while flushing: newest target wins
    drive(1, 0, 0, 1, 32'h200);
    expect_out("fl_a", 1, 32'h0, 0, 0);
    drive(1, 0, 0, 1, 32'h300);
    expect_out("fl_b", 1, 32'h0, 0, 0);
    drive(1, 1, 0, 0, 0);
    expect_out("fl_c", 1, 32'h0, 0, 0);
    drive(1, 0, 0, 1, 32'hFFFF_FFFF);
    expect_out("fl_d", 1, 32'h300, 0, 0);

    // pc wrap from 0xFFFFFFFF to 0
    drive(1, 1, 0, 0, 0);
    expect_out("wr_a", 1, 32'h300, 0, 0);
    drive(1, 1, 0, 0, 0);
    expect_out("wr_b", 1, 32'hFFFF_FFFF, 0, 0);
    drive(1, 0, 0, 0, 0);
    expect_out("wr_c", 1, 32'h0, 1, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, prefetch buffer entries (power of two, >=2).
REQ-002 Parameter RESET_PC, default 32'h0, first word address fetched after reset.
REQ-003 clock  input  1  single clock; all state updates on posedge clock.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 imem_req  output  1  fetch request to instruction memory, registered.
REQ-006 imem_addr  output  32  word address of the request; stable while imem_req=1 and imem_ack=0.
REQ-007 imem_ack  input  1  memory accepts the request and returns data in the same cycle; ignored when imem_req=0.
REQ-008 imem_rdata  input  32  instruction word, valid when imem_req=1 and imem_ack=1.
REQ-009 redirect  input  1  core branch/jump/jal/jr taken; flush and refetch.
REQ-010 redirect_pc  input  32  new word address, sampled when redirect=1.
REQ-011 inst_valid  output  1  head buffer entry valid.
REQ-012 inst  output  32  head instruction word.
REQ-013 inst_pc  output  32  word address of the head instruction.
REQ-014 inst_ready  input  1  core consumes the head entry when inst_valid=1 and inst_ready=1.

Function
REQ-015 Addresses are word-indexed; sequential fetch increments fetch_pc by 1, modulo 2^32 (32'hFFFFFFFF -> 32'h0).
REQ-016 The buffer is a DEPTH-entry FIFO of {pc, word}, first-word fall-through: inst_valid = (count != 0), inst and inst_pc driven from the head entry.
REQ-017 At most one request is outstanding; a new request is issued only when count + outstanding < DEPTH, after accounting for the pop this cycle.
REQ-018 States: IDLE (no request), REQ (imem_req=1, addr=fetch_pc), FLUSH (imem_req=1, stale address held; returned data discarded).
REQ-019 IDLE -> REQ when space exists and redirect=0; imem_req rises the cycle after the decision.
REQ-020 REQ, imem_ack=1, redirect=0: push {fetch_pc, imem_rdata}; fetch_pc += 1; stay REQ if space remains for the next word, else -> IDLE; back-to-back acks give one word per cycle.
REQ-021 REQ, imem_ack=0: hold imem_req and imem_addr unchanged.
REQ-022 Pop occurs when inst_valid=1 and inst_ready=1; simultaneous push and pop leaves count unchanged.
REQ-023 redirect=1 in any state: FIFO emptied (count=0) at the next edge; fetch_pc <= redirect_pc; any push or pop in the same cycle is discarded.
REQ-024 redirect=1 in REQ with imem_ack=0 -> FLUSH; the old request stays asserted with its old address until acked.
REQ-025 redirect=1 in REQ with imem_ack=1: data discarded; -> REQ at redirect_pc next cycle.
REQ-026 FLUSH, imem_ack=1: data discarded; -> REQ at current fetch_pc next cycle.
REQ-027 redirect=1 in FLUSH: fetch_pc updated to the newest redirect_pc; remain in FLUSH until the stale ack arrives.
REQ-028 inst_valid stays 0 from the cycle after a redirect until the first post-redirect word is pushed.
REQ-029 Overflow is impossible by construction; an imem_ack with imem_req=0 has no effect.

Reset
REQ-030 While reset_n=0 at a posedge: state=IDLE, count=0, read/write pointers=0, fetch_pc=RESET_PC, imem_req=0, inst_valid=0.
REQ-031 Reset asserted mid-request abandons the request; any later ack while imem_req=0 is ignored.
REQ-032 First request after reset release: imem_req=1, imem_addr=RESET_PC.

Verification
REQ-033 Reset release, imem_ack tied 1, inst_ready=0 -> exactly DEPTH words (pc 0..3) buffered, imem_req=0, inst_pc=0 held.
REQ-034 imem_ack=1, inst_ready=1 continuously -> one instruction per cycle, inst_pc 0,1,2,... with no gaps after the first.
REQ-035 imem_ack held 0 for 3 cycles -> imem_addr stable throughout, inst_valid=0, no push.
REQ-036 Buffer holds pc 4..7, redirect=1 with redirect_pc=32'h40, no outstanding request -> next cycle inst_valid=0; next delivered inst_pc=32'h40.
REQ-037 Request for pc 5 outstanding, redirect to 32'h80, ack 2 cycles later -> stale word discarded, next request imem_addr=32'h80, inst_pc 5 never appears at the output.
REQ-038 fetch_pc=32'hFFFFFFFF, ack -> next imem_addr=32'h0; RESET_PC=32'h100 -> first imem_addr=32'h100.
